pipeline_stall_ctrl: RTL

Sequencing controller for the OTTER five-stage pipeline (IF, DE, EX, MEM, WB; no forwarding). It detects RAW register hazards between the DE-stage instruction and older instructions in EX, MEM and WB. It then holds the front end for the exact number of cycles required, inserting bubbles into DE/EX, and flushes the front end on a taken branch or jump resolved in EX. It drives the PC write enable and the IF/DE and DE/EX register controls, and keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 37 +++
 rtl/pipeline_stall_ctrl_if.sv | 33 +++
 rtl/pipeline_stall_ctrl_hazard_match.sv | 32 +++
 rtl/pipeline_stall_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared OTTER definitions: opcode encodings, the NOP word and the stall FSM states.
// Also holds the operand-usage rules consumed by hazard detection.
package otter_pkg;

  typedef enum logic [6:0] {
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    BRANCH = 7'b1100011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    OP_IMM = 7'b0010011,
    OP     = 7'b0110011,
    SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic {RUN, STALL} stall_state_t;

  // Per-cycle control action, decoded into the five pipeline control outputs.
  typedef enum logic [1:0] {CTL_IDLE, CTL_STALL, CTL_FLUSH, CTL_FREEZE} ctl_mode_t;

  localparam logic [31:0] NOP = 32'h00000013;

  function automatic logic writes_rd(opcode_t op);
    return (op != BRANCH) && (op != STORE);
  endfunction

  function automatic logic uses_rs1(opcode_t op);
    return (op != LUI) && (op != AUIPC) && (op != JAL);
  endfunction

  function automatic logic uses_rs2(opcode_t op);
    return (op == BRANCH) || (op == STORE) || (op == OP);
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Pipeline-side bundle: stage instructions in, front-end control out.
// The pipeline drives the master side; the stall controller is the slave.
interface pipeline_stall_ctrl_if;

  logic [31:0] de_ir;
  logic        de_valid;
  logic [31:0] ex_ir;
  logic        ex_valid;
  logic [31:0] mem_ir;
  logic        mem_valid;
  logic [31:0] wb_ir;
  logic        wb_valid;
  logic        br_taken;
  logic        mem_busy;
  logic        pc_write;
  logic        if_de_en;
  logic        if_de_clear;
  logic        de_ex_clear;
  logic        stalled;

  modport master (
    output de_ir, de_valid, ex_ir, ex_valid, mem_ir, mem_valid, wb_ir, wb_valid,
           br_taken, mem_busy,
    input  pc_write, if_de_en, if_de_clear, de_ex_clear, stalled
  );

  modport slave (
    input  de_ir, de_valid, ex_ir, ex_valid, mem_ir, mem_valid, wb_ir, wb_valid,
           br_taken, mem_busy,
    output pc_write, if_de_en, if_de_clear, de_ex_clear, stalled
  );

endinterface

// File: rtl/pipeline_stall_ctrl_hazard_match.sv
// RAW match between one older producer instruction and the DE-stage consumer.
// x0 is never a real dependency, so a producer with rd=x0 is not a writer.
module hazard_match
  import otter_pkg::*;
(
  input  logic [31:0] prod_ir,
  input  logic        prod_valid,
  input  logic [31:0] de_ir,
  input  logic        de_valid,
  output logic        match
);

  opcode_t    prod_op;
  opcode_t    de_op;
  logic [4:0] rd;
  logic       writer;
  logic       rs1_hit;
  logic       rs2_hit;
  logic       unused_bits;

  assign prod_op = opcode_t'(prod_ir[6:0]);
  assign de_op   = opcode_t'(de_ir[6:0]);
  assign rd      = prod_ir[11:7];

  assign writer  = prod_valid && writes_rd(prod_op) && (rd != 5'd0);
  assign rs1_hit = uses_rs1(de_op) && (de_ir[19:15] == rd);
  assign rs2_hit = uses_rs2(de_op) && (de_ir[24:20] == rd);
  assign match   = de_valid && writer && (rs1_hit || rs2_hit);

  assign unused_bits = ^{prod_ir[31:12], de_ir[31:25], de_ir[14:7]};

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// OTTER front-end sequencer: RAW-hazard stalls, branch flushes and memory freezes,
// plus a saturating count of hazard-stall cycles.
module pipeline_stall_ctrl
  import otter_pkg::*;
#(
  parameter int RF_BYPASS = 0,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_stall_ctrl_if.slave bus,
  output logic [CNT_W-1:0]     stall_cycles
);

  // A write-through register file hides one cycle of every producer's distance.
  localparam logic [1:0] N_EX  = 2'(3 - RF_BYPASS);
  localparam logic [1:0] N_MEM = 2'(2 - RF_BYPASS);
  localparam logic [1:0] N_WB  = 2'(1 - RF_BYPASS);

  logic         ex_hit;
  logic         mem_hit;
  logic         wb_hit;
  logic [1:0]   n_req;
  stall_state_t state_q;
  stall_state_t state_d;
  logic [1:0]   cnt_q;
  logic [1:0]   cnt_d;
  ctl_mode_t    mode;

  hazard_match u_ex_match (
    .prod_ir   (bus.ex_ir),
    .prod_valid(bus.ex_valid),
    .de_ir     (bus.de_ir),
    .de_valid  (bus.de_valid),
    .match     (ex_hit)
  );

  hazard_match u_mem_match (
    .prod_ir   (bus.mem_ir),
    .prod_valid(bus.mem_valid),
    .de_ir     (bus.de_ir),
    .de_valid  (bus.de_valid),
    .match     (mem_hit)
  );

  hazard_match u_wb_match (
    .prod_ir   (bus.wb_ir),
    .prod_valid(bus.wb_valid),
    .de_ir     (bus.de_ir),
    .de_valid  (bus.de_valid),
    .match     (wb_hit)
  );

  // The youngest matching producer needs the longest wait, so it takes priority.
  always_comb begin
    if (ex_hit)       n_req = N_EX;
    else if (mem_hit) n_req = N_MEM;
    else if (wb_hit)  n_req = N_WB;
    else              n_req = 2'd0;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode    = CTL_IDLE;
    if (rst) begin
      state_d = RUN;
      cnt_d   = 2'd0;
    end else if (bus.mem_busy) begin
      mode = CTL_FREEZE;
    end else if (bus.br_taken) begin
      mode    = CTL_FLUSH;
      state_d = RUN;
      cnt_d   = 2'd0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (n_req != 2'd0) begin
            mode = CTL_STALL;
            if (n_req > 2'd1) begin
              state_d = STALL;
              cnt_d   = n_req - 2'd1;
            end
          end
        end
        STALL: begin
          mode  = CTL_STALL;
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    bus.pc_write    = 1'b1;
    bus.if_de_en    = 1'b1;
    bus.if_de_clear = 1'b0;
    bus.de_ex_clear = 1'b0;
    bus.stalled     = 1'b0;
    unique case (mode)
      CTL_STALL: begin
        bus.pc_write    = 1'b0;
        bus.if_de_en    = 1'b0;
        bus.de_ex_clear = 1'b1;
        bus.stalled     = 1'b1;
      end
      CTL_FLUSH: begin
        bus.if_de_clear = 1'b1;
        bus.de_ex_clear = 1'b1;
      end
      CTL_FREEZE: begin
        bus.pc_write = 1'b0;
        bus.if_de_en = 1'b0;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (bus.stalled && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
